// File: rtl/three_bit_updown_monitor_if.sv
// ============================================================================
//  three_bit_updown_monitor_if
//  Bundle between a 3-bit up/down counter and its health monitor.
//  Signals:
//    q_in      counter value sampled by the monitor
//    m         counter mode, 0 = up, 1 = down
//    locked    monitor is tracking the counter
//    err       one-cycle pulse on a bad step while locked
//    err_count saturating count of err pulses (ERR_W bits)
//    dir       direction of the last correct step
//    wrap      one-cycle pulse on a correct 7->0 / 0->7 step
//  Modports: master = counter side (drives q_in/m), slave = monitor side.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface three_bit_updown_monitor_if #(
  parameter int ERR_W = 4
);
  logic [2:0]       q_in;
  logic             m;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_count;
  logic             dir;
  logic             wrap;

  modport master (
    output q_in, m,
    input  locked, err, err_count, dir, wrap
  );

  modport slave (
    input  q_in, m,
    output locked, err, err_count, dir, wrap
  );
endinterface

`default_nettype wire

// File: rtl/three_bit_updown_monitor.sv
// ============================================================================
//  three_bit_updown_monitor
//  Checks the output stream of a 3-bit synchronous up/down counter. Each
//  sample is compared with the value predicted from the previous sample and
//  the mode captured alongside it; the monitor reports lock, direction,
//  wrap-around and step errors, all registered.
//  Ports:
//    clk  clock, rising edge
//    clr  asynchronous active-low clear
//    mon  slave side of three_bit_updown_monitor_if
//  Parameters:
//    LOCK_CNT  consecutive correct steps needed to lock (1..7)
//    ERR_W     width of err_count
//  Build option:
//    UPDOWN_MON_STALL_EN  when defined, a repeated value is a legal stall
//                         (no error, no progress).
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module three_bit_updown_monitor #(
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 4
) (
  input  logic                         clk,
  input  logic                         clr,
  three_bit_updown_monitor_if.slave    mon
);

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  state_t           state_q;
  logic [2:0]       q_prev_q;
  logic             m_prev_q;
  logic [2:0]       run_q;
  logic             locked_q;
  logic             err_q;
  logic [ERR_W-1:0] err_count_q;
  logic             dir_q;
  logic             wrap_q;

  logic [2:0]       exp_d;
  logic [3:0]       run_d;
  logic [ERR_W-1:0] err_count_d;
  logic             step_ok;
  logic             wrap_hit;
  logic             stall;

  // Prediction uses the mode captured with the previous sample, so a mode
  // change only affects the step after it is sampled.
  always_comb begin
    exp_d       = m_prev_q ? (q_prev_q - 3'd1) : (q_prev_q + 3'd1);
    step_ok     = (mon.q_in == exp_d);
    wrap_hit    = m_prev_q ? (q_prev_q == 3'd0) : (q_prev_q == 3'd7);
    run_d       = {1'b0, run_q} + 4'd1;
    err_count_d = (err_count_q == {ERR_W{1'b1}}) ? err_count_q
                                                 : err_count_q + ERR_W'(1);
  end

`ifdef UPDOWN_MON_STALL_EN
  // A held value can never equal the prediction, so stall and step_ok are
  // mutually exclusive.
  assign stall = (mon.q_in == q_prev_q);
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= ACQ;
      q_prev_q    <= 3'd0;
      m_prev_q    <= 1'b0;
      run_q       <= 3'd0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      dir_q       <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      q_prev_q <= mon.q_in;
      m_prev_q <= mon.m;
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;

      case (state_q)
        ACQ: begin
          run_q   <= 3'd0;
          state_q <= SYNC;
        end

        SYNC: begin
          if (step_ok) begin
            run_q  <= run_d[2:0];
            dir_q  <= m_prev_q;
            wrap_q <= wrap_hit;
            if (run_d == LOCK_TGT) begin
              state_q  <= TRACK;
              locked_q <= 1'b1;
            end
          end else if (!stall) begin
            run_q <= 3'd0;
          end
        end

        TRACK: begin
          if (step_ok) begin
            dir_q  <= m_prev_q;
            wrap_q <= wrap_hit;
          end else if (!stall) begin
            err_q       <= 1'b1;
            err_count_q <= err_count_d;
            locked_q    <= 1'b0;
            run_q       <= 3'd0;
            state_q     <= SYNC;
          end
        end

        default: begin
          state_q <= ACQ;
        end
      endcase
    end
  end

  assign mon.locked    = locked_q;
  assign mon.err       = err_q;
  assign mon.err_count = err_count_q;
  assign mon.dir       = dir_q;
  assign mon.wrap      = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_three_bit_updown_monitor.sv
// ============================================================================
//  tb_three_bit_updown_monitor
//  Directed bench for three_bit_updown_monitor with hand-computed expectations.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_three_bit_updown_monitor;

  logic clk;
  logic clr;

  int n_checks;
  int n_pass;

  three_bit_updown_monitor_if #(.ERR_W(4)) bus ();

  three_bit_updown_monitor #(
    .LOCK_CNT (3),
    .ERR_W    (4)
  ) u_dut (
    .clk (clk),
    .clr (clr),
    .mon (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs == exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Present one sample, let one rising edge take it, then settle 1 ns.
  task automatic drive(input logic [2:0] q, input logic md);
    bus.q_in = q;
    bus.m    = md;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] cur;
    logic [2:0] bad;
    int         ec;

    n_checks = 0;
    n_pass   = 0;
    clr      = 1'b0;
    bus.q_in = 3'd0;
    bus.m    = 1'b0;

    #2;
    check_eq("rst_locked", int'(bus.locked), 0);
    check_eq("rst_errcnt", int'(bus.err_count), 0);
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;

    // Clean up-count: lock after the 4th edge, wrap on 7->0.
    drive(3'd0, 1'b0);
    check_eq("acq_locked", int'(bus.locked), 0);
    drive(3'd1, 1'b0);
    drive(3'd2, 1'b0);
    check_eq("edge3_locked", int'(bus.locked), 0);
    drive(3'd3, 1'b0);
    check_eq("edge4_locked", int'(bus.locked), 1);
    drive(3'd4, 1'b0);
    drive(3'd5, 1'b0);
    drive(3'd6, 1'b0);
    drive(3'd7, 1'b0);
    check_eq("pre_wrap", int'(bus.wrap), 0);
    drive(3'd0, 1'b0);
    check_eq("up_wrap", int'(bus.wrap), 1);
    check_eq("up_dir", int'(bus.dir), 0);
    check_eq("up_errcnt", int'(bus.err_count), 0);
    drive(3'd1, 1'b0);
    check_eq("wrap_one_cycle", int'(bus.wrap), 0);

    // Mode flips to down when 5 is presented; step to 4 is then correct.
    drive(3'd2, 1'b0);
    drive(3'd3, 1'b0);
    drive(3'd4, 1'b0);
    drive(3'd5, 1'b1);
    check_eq("flip_dir_hold", int'(bus.dir), 0);
    drive(3'd4, 1'b1);
    check_eq("flip_dir", int'(bus.dir), 1);
    check_eq("flip_err", int'(bus.err), 0);
    drive(3'd3, 1'b1);
    check_eq("flip_locked", int'(bus.locked), 1);

    // Down-count through 0 -> 7.
    drive(3'd2, 1'b1);
    drive(3'd1, 1'b1);
    drive(3'd0, 1'b1);
    check_eq("dn_prewrap", int'(bus.wrap), 0);
    drive(3'd7, 1'b1);
    check_eq("dn_wrap", int'(bus.wrap), 1);
    check_eq("dn_dir", int'(bus.dir), 1);
    drive(3'd6, 1'b1);
    check_eq("dn_wrap_end", int'(bus.wrap), 0);

    // Back to up, reach 3, then inject 6.
    drive(3'd5, 1'b0);
    drive(3'd6, 1'b0);
    drive(3'd7, 1'b0);
    drive(3'd0, 1'b0);
    drive(3'd1, 1'b0);
    drive(3'd2, 1'b0);
    drive(3'd3, 1'b0);
    check_eq("up_again_dir", int'(bus.dir), 0);
    drive(3'd6, 1'b0);
    check_eq("inj_err", int'(bus.err), 1);
    check_eq("inj_locked", int'(bus.locked), 0);
    check_eq("inj_errcnt", int'(bus.err_count), 1);
    drive(3'd7, 1'b0);
    check_eq("inj_err_pulse", int'(bus.err), 0);
    drive(3'd0, 1'b0);
    check_eq("sync_wrap", int'(bus.wrap), 1);
    check_eq("relock_2", int'(bus.locked), 0);
    drive(3'd1, 1'b0);
    check_eq("relock_3", int'(bus.locked), 1);

    // 20 more errors with relock in between: count saturates at 15.
    cur = 3'd1;
    ec  = 1;
    for (int i = 0; i < 20; i++) begin
      bad = cur + 3'd2;
      drive(bad, 1'b0);
      ec = (ec < 15) ? ec + 1 : 15;
      check_eq("sat_err", int'(bus.err), 1);
      check_eq("sat_cnt", int'(bus.err_count), ec);
      cur = bad;
      for (int k = 0; k < 3; k++) begin
        cur = cur + 3'd1;
        drive(cur, 1'b0);
      end
      check_eq("sat_relock", int'(bus.locked), 1);
    end
    check_eq("sat_final", int'(bus.err_count), 15);

    // Repeated value while locked.
    drive(cur, 1'b0);
`ifdef UPDOWN_MON_STALL_EN
    check_eq("stall_err", int'(bus.err), 0);
    check_eq("stall_locked", int'(bus.locked), 1);
`else
    check_eq("stall_err", int'(bus.err), 1);
    check_eq("stall_locked", int'(bus.locked), 0);
    for (int k = 0; k < 3; k++) begin
      cur = cur + 3'd1;
      drive(cur, 1'b0);
    end
    check_eq("stall_relock", int'(bus.locked), 1);
`endif
    check_eq("stall_cnt", int'(bus.err_count), 15);

    // Go down one step so dir is 1, then clear mid-cycle.
    cur = cur + 3'd1;
    drive(cur, 1'b1);
    cur = cur - 3'd1;
    drive(cur, 1'b1);
    check_eq("pre_clr_dir", int'(bus.dir), 1);
    clr = 1'b0;
    #1;
    check_eq("clr_locked", int'(bus.locked), 0);
    check_eq("clr_errcnt", int'(bus.err_count), 0);
    check_eq("clr_dir", int'(bus.dir), 0);
    check_eq("clr_err", int'(bus.err), 0);
    check_eq("clr_wrap", int'(bus.wrap), 0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    drive(3'd0, 1'b0);
    drive(3'd1, 1'b0);
    drive(3'd2, 1'b0);
    check_eq("reacq_3", int'(bus.locked), 0);
    drive(3'd3, 1'b0);
    check_eq("reacq_4", int'(bus.locked), 1);
    check_eq("reacq_cnt", int'(bus.err_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
